// File: rtl/vga_frame_analyzer.sv
// Receive-side monitor for a TinyVGA PMOD stream: recovers pixel position from the syncs,
// checks sync timing and reports the per-frame bounding box of non-background pixels.
module vga_frame_analyzer #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_START  = 144,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_START  = 35,
  parameter int unsigned V_ACTIVE = 480,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic        frame_done,
  output logic        locked,
  output logic        obj_valid,
  output logic [9:0]  box_x0,
  output logic [8:0]  box_y0,
  output logic [9:0]  box_x1,
  output logic [8:0]  box_y1,
  output logic [18:0] diff_count
);

  localparam int unsigned HW   = 11;
  localparam int unsigned VW   = 10;
  localparam int unsigned XW   = 10;
  localparam int unsigned YW   = 9;
  localparam int unsigned CW   = 19;
  localparam int unsigned COLW = 6;

  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;
  localparam logic [CW-1:0] C_MAX = '1;

  typedef enum logic {
    SEARCH  = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [7:0]      s_vga;
  logic            prev_hs, prev_vs;
  logic [COLW-1:0] pix_col;
  logic            hs_edge, vs_edge;

  logic [HW-1:0]   hcnt;
  logic [VW-1:0]   vcnt;

  logic            h_act, v_act, pix_act, pix_origin, pix_diff;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;

  logic [COLW-1:0] bg;
  logic [CW-1:0]   acc_count;
  logic [XW-1:0]   acc_x0, acc_x1;
  logic [YW-1:0]   acc_y0, acc_y1;
  logic            acc_any;

  logic            line_ok, frame_ok, line_ok_nxt, frame_ok_nxt;
  logic            publish, lost;

  // Sample stage; pix_col lags one more cycle so it lines up with hcnt after an hsync edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_vga   <= '0;
      prev_hs <= SYNC_POL;
      prev_vs <= SYNC_POL;
      pix_col <= '0;
    end else begin
      s_vga   <= vga_in;
      prev_hs <= s_vga[7];
      prev_vs <= s_vga[3];
      pix_col <= {s_vga[0], s_vga[4], s_vga[1], s_vga[5], s_vga[2], s_vga[6]};
    end
  end

  assign hs_edge = (s_vga[7] == SYNC_POL) && (prev_hs != SYNC_POL);
  assign vs_edge = (s_vga[3] == SYNC_POL) && (prev_vs != SYNC_POL);

  // Position counters; vsync edge overrides the line increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (hs_edge)            hcnt <= '0;
      else if (hcnt != H_MAX) hcnt <= hcnt + HW'(1);

      if (vs_edge)                        vcnt <= '0;
      else if (hs_edge && vcnt != V_MAX)  vcnt <= vcnt + VW'(1);
    end
  end

  assign h_act      = (hcnt >= HW'(H_START)) && (hcnt < HW'(H_START + H_ACTIVE));
  assign v_act      = (vcnt >= VW'(V_START)) && (vcnt < VW'(V_START + V_ACTIVE));
  assign pix_x      = XW'(hcnt - HW'(H_START));
  assign pix_y      = YW'(vcnt - VW'(V_START));
  assign pix_act    = h_act && v_act;
  assign pix_origin = pix_act && (pix_x == '0) && (pix_y == '0);
  assign pix_diff   = pix_act && !pix_origin && (pix_col != bg);
  assign acc_any    = (acc_count != '0);

  // Per-frame accumulators, restarted at every vsync edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bg        <= '0;
      acc_count <= '0;
      acc_x0    <= '0;
      acc_x1    <= '0;
      acc_y0    <= '0;
      acc_y1    <= '0;
    end else if (vs_edge) begin
      acc_count <= '0;
      acc_x0    <= '0;
      acc_x1    <= '0;
      acc_y0    <= '0;
      acc_y1    <= '0;
    end else begin
      if (pix_origin) bg <= pix_col;
      if (pix_diff) begin
        if (acc_count != C_MAX) acc_count <= acc_count + CW'(1);
        if (!acc_any) begin
          acc_x0 <= pix_x;
          acc_x1 <= pix_x;
          acc_y0 <= pix_y;
          acc_y1 <= pix_y;
        end else begin
          if (pix_x < acc_x0) acc_x0 <= pix_x;
          if (pix_x > acc_x1) acc_x1 <= pix_x;
          if (pix_y < acc_y0) acc_y0 <= pix_y;
          if (pix_y > acc_y1) acc_y1 <= pix_y;
        end
      end
    end
  end

  // Fresh check results so a publish reflects the line/frame that just ended
  assign line_ok_nxt  = hs_edge ? ((12'(hcnt) + 12'd1) == 12'(H_TOTAL)) : line_ok;
  assign frame_ok_nxt = vs_edge ? ((11'(vcnt) + 11'd1) == 11'(V_TOTAL)) : frame_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_ok  <= 1'b0;
      frame_ok <= 1'b0;
    end else begin
      line_ok  <= line_ok_nxt;
      frame_ok <= frame_ok_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  // Losing hsync takes priority over a coincident vsync edge
  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    lost      = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_edge) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (hcnt == H_MAX) begin
          state_nxt = SEARCH;
          lost      = 1'b1;
        end else if (vs_edge) begin
          publish = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      locked     <= 1'b0;
      obj_valid  <= 1'b0;
      box_x0     <= '0;
      box_y0     <= '0;
      box_x1     <= '0;
      box_y1     <= '0;
      diff_count <= '0;
    end else begin
      frame_done <= publish;
      if (publish) begin
        locked     <= line_ok_nxt && frame_ok_nxt;
        obj_valid  <= acc_any;
        diff_count <= acc_count;
        box_x0     <= acc_any ? acc_x0 : '0;
        box_y0     <= acc_any ? acc_y0 : '0;
        box_x1     <= acc_any ? acc_x1 : '0;
        box_y1     <= acc_any ? acc_y1 : '0;
      end else if (lost) begin
        locked <= 1'b0;
      end
    end
  end

endmodule
